fret_strum_conditioner: RTL

FRET_STRUM_CONDITIONER -- requirements
Module: fret_strum_conditioner

---
 rtl/fret_strum_conditioner_if.sv | 20 ++
 rtl/fret_strum_conditioner.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fret_strum_conditioner_if.sv
// Signal bundle between the guitar GPIO side and fret_strum_conditioner.
interface fret_strum_conditioner_if;
   logic [4:0] buttons_raw;
   logic       strum_raw;
   logic       pause;
   logic [4:0] buttons_db;
   logic       strum_pulse;
   logic [4:0] chord;
   logic [7:0] strum_count;

   modport master (
      output buttons_raw, strum_raw, pause,
      input  buttons_db, strum_pulse, chord, strum_count
   );

   modport slave (
      input  buttons_raw, strum_raw, pause,
      output buttons_db, strum_pulse, chord, strum_count
   );
endinterface

// File: rtl/fret_strum_conditioner.sv
// Guitar input conditioner: synchronize, debounce, strum strobe with chord snapshot.
// Build macro GUITAR_INPUT_ACTIVE_LOW_EN inverts the raw switch inputs.
module fret_strum_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic                    clk,
   input  logic                    reset,
   fret_strum_conditioner_if.slave bus
);
   localparam int CNT_W = 24;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE, HELD} state_t;

   logic [1:0] rst_pipe;
   logic       rst;
   logic [5:0] raw_in;
   logic [5:0] sync_meta;
   logic [5:0] sync_q;
   logic [5:0] stable;
   logic [1:0] sync_fill;
   logic       armed;
   logic       strum_db;
   state_t     state;
   state_t     state_nxt;
   logic       pulse_nxt;
   logic       pulse_q;
   logic [4:0] chord_q;
   logic [7:0] count_q;

   // Reset asserts at once but releases two edges later, clean of clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rst_pipe <= 2'b11;
      else       rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst = rst_pipe[1];

   // Bit 5 carries the strum switch, bits 4:0 the frets.
`ifdef GUITAR_INPUT_ACTIVE_LOW_EN
   assign raw_in = ~{bus.strum_raw, bus.buttons_raw};
`else
   assign raw_in = {bus.strum_raw, bus.buttons_raw};
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta <= '0;
         sync_q    <= '0;
      end else begin
         sync_meta <= raw_in;
         sync_q    <= sync_meta;
      end
   end

   for (genvar i = 0; i < 6; i++) begin : g_db
      logic [CNT_W-1:0] cnt;
      logic             stable_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt      <= '0;
            stable_q <= 1'b0;
         end else if (sync_q[i] == stable_q) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stable_q <= ~stable_q;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign stable[i] = stable_q;
   end

   assign strum_db = stable[5];

   // A strum held through reset must be released before it can pulse again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_fill <= 2'b00;
         armed     <= 1'b0;
      end else begin
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && !sync_q[5]) armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no latch can be inferred.
   always_comb begin
      state_nxt = state;
      pulse_nxt = 1'b0;
      case (state)
         IDLE: if (strum_db) begin
            state_nxt = HELD;
            pulse_nxt = armed && !bus.pause;
         end
         HELD: if (!strum_db) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_q <= 1'b0;
         chord_q <= '0;
         count_q <= '0;
      end else begin
         pulse_q <= pulse_nxt;
         if (pulse_nxt) chord_q <= stable[4:0];
         count_q <= count_q + {7'd0, pulse_q};
      end
   end

   assign bus.buttons_db  = stable[4:0];
   assign bus.strum_pulse = pulse_q;
   assign bus.chord       = chord_q;
   assign bus.strum_count = count_q;
endmodule
